// File: rtl/spi_multi_io.sv
`default_nettype none
// ============================================================================
// Module      : spi_multi_io
// Description : Mode-0 SPI slave, oversampled on clk. Single, dual and quad
//               read commands with address/dummy phases; other commands
//               receive single-lane data bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_multi_io #(
    parameter int ADDR_BYTES  = 3,
    parameter int DUMMY_FAST  = 8,
    parameter int DUMMY_QIO   = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    spi_clk_in,
    input  logic                    spi_cs_in,
    input  logic [3:0]              spi_data_in,
    output logic [3:0]              spi_data_out,
    output logic [3:0]              spi_data_oe,
    output logic [7:0]              byte_rx,
    input  logic [7:0]              byte_tx,
    output logic [8*ADDR_BYTES-1:0] addr,
    output logic                    spi_cmd_strobe,
    output logic                    spi_addr_strobe,
    output logic                    spi_byte_strobe,
    output logic                    spi_tx_strobe
);

    localparam logic [2:0]  c_IDLE      = 3'd0;
    localparam logic [2:0]  c_CMD       = 3'd1;
    localparam logic [2:0]  c_ADDR      = 3'd2;
    localparam logic [2:0]  c_DUMMY     = 3'd3;
    localparam logic [2:0]  c_DATA_OUT  = 3'd4;
    localparam logic [2:0]  c_DATA_IN   = 3'd5;

    localparam logic [1:0]  c_LN1       = 2'd0;
    localparam logic [1:0]  c_LN2       = 2'd1;
    localparam logic [1:0]  c_LN4       = 2'd2;

    localparam logic [15:0] c_ADDR_BITS = 16'(8 * ADDR_BYTES);
    // {valid, spi_clk, cs, data}: valid marks entries that carry real pin samples
    localparam logic [6:0]  c_SYNC_RST  = 7'b0010000;

    logic [6:0]              r_sync [SYNC_STAGES];
    logic                    r_sclk_d;
    logic                    r_armed;
    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [15:0]             r_cnt;
    logic [6:0]              r_shift;
    logic [7:0]              r_byte;
    logic [8*ADDR_BYTES-1:0] r_addr;
    logic [15:0]             r_dummy;
    logic [1:0]              r_out_mode;
    logic                    r_addr_quad;
    logic [6:0]              r_tx;
    logic [3:0]              r_dout;
    logic                    r_cmd_stb;
    logic                    r_addr_stb;
    logic                    r_byte_stb;
    logic                    r_tx_stb;

    logic [6:0]              w_sync;
    logic                    w_sclk;
    logic                    w_cs;
    logic [3:0]              w_din;
    logic                    w_rise;
    logic                    w_fall;
    logic [7:0]              w_shift_nxt;
    logic                    w_last;
    logic [15:0]             w_addr_step;
    logic                    w_dec_read;
    logic                    w_dec_quad;
    logic [1:0]              w_dec_mode;
    logic [15:0]             w_dec_dummy;
    logic [7:0]              w_tx_shift;
    logic [7:0]              w_tx_src;
    logic [3:0]              w_dout_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= c_SYNC_RST;
        end else begin
            r_sync[0] <= {1'b1, spi_clk_in, spi_cs_in, spi_data_in};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_sclk      = w_sync[5];
    assign w_cs        = w_sync[4];
    assign w_din       = w_sync[3:0];
    assign w_rise      = w_sclk & ~r_sclk_d;
    assign w_fall      = ~w_sclk & r_sclk_d;
    assign w_shift_nxt = {r_shift, w_din[0]};
    assign w_addr_step = r_addr_quad ? 16'd4 : 16'd1;

    always_comb begin
        w_dec_read  = 1'b1;
        w_dec_quad  = 1'b0;
        w_dec_mode  = c_LN1;
        w_dec_dummy = 16'd0;
        case (w_shift_nxt)
            8'h03: ;
            8'h0B: w_dec_dummy = 16'(DUMMY_FAST);
            8'h3B: begin
                w_dec_dummy = 16'(DUMMY_FAST);
                w_dec_mode  = c_LN2;
            end
            8'h6B: begin
                w_dec_dummy = 16'(DUMMY_FAST);
                w_dec_mode  = c_LN4;
            end
            8'hEB: begin
                w_dec_dummy = 16'(DUMMY_QIO);
                w_dec_mode  = c_LN4;
                w_dec_quad  = 1'b1;
            end
            default: w_dec_read = 1'b0;
        endcase
    end

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            c_CMD, c_DATA_IN: w_last = (r_cnt == 16'd7);
            c_ADDR:           w_last = (r_cnt == c_ADDR_BITS - w_addr_step);
            c_DUMMY:          w_last = (r_cnt == r_dummy - 16'd1);
            c_DATA_OUT: begin
                case (r_out_mode)
                    c_LN1:   w_last = (r_cnt == 16'd7);
                    c_LN2:   w_last = (r_cnt == 16'd3);
                    default: w_last = (r_cnt == 16'd1);
                endcase
            end
            default: ;
        endcase
    end

    // A count of zero means the current byte is finished: take a fresh byte_tx
    always_comb begin
        case (r_out_mode)
            c_LN1:   w_tx_shift = {r_tx, 1'b0};
            c_LN2:   w_tx_shift = {r_tx[5:0], 2'b00};
            default: w_tx_shift = {r_tx[3:0], 4'b0000};
        endcase
        w_tx_src = (r_cnt == 16'd0) ? byte_tx : w_tx_shift;
        case (r_out_mode)
            c_LN1:   w_dout_nxt = {2'b00, w_tx_src[7], 1'b0};
            c_LN2:   w_dout_nxt = {2'b00, w_tx_src[7:6]};
            default: w_dout_nxt = w_tx_src[7:4];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state != c_IDLE && w_cs) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (r_armed && !w_cs) w_state_nxt = c_CMD;
                c_CMD:   if (w_rise && w_last) w_state_nxt = w_dec_read ? c_ADDR : c_DATA_IN;
                c_ADDR:  if (w_rise && w_last) w_state_nxt = (r_dummy == 16'd0) ? c_DATA_OUT : c_DUMMY;
                c_DUMMY: if (w_rise && w_last) w_state_nxt = c_DATA_OUT;
                default: ;
            endcase
        end
    end

    always_comb begin
        spi_data_oe = 4'b0000;
        if (r_state == c_DATA_OUT) begin
            case (r_out_mode)
                c_LN1:   spi_data_oe = 4'b0010;
                c_LN2:   spi_data_oe = 4'b0011;
                default: spi_data_oe = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sclk_d    <= 1'b0;
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_byte      <= '0;
            r_addr      <= '0;
            r_dummy     <= '0;
            r_out_mode  <= c_LN1;
            r_addr_quad <= 1'b0;
            r_tx        <= '0;
            r_dout      <= '0;
            r_cmd_stb   <= 1'b0;
            r_addr_stb  <= 1'b0;
            r_byte_stb  <= 1'b0;
            r_tx_stb    <= 1'b0;
        end else begin
            r_sclk_d   <= w_sclk;
            // Only a cs seen high after reset may open a transaction
            r_armed    <= r_armed | (w_sync[6] & w_cs);
            r_cmd_stb  <= 1'b0;
            r_addr_stb <= 1'b0;
            r_byte_stb <= 1'b0;
            r_tx_stb   <= 1'b0;
            if (r_state == c_IDLE || w_cs) begin
                r_cnt <= '0;
                if (w_cs) r_dout <= '0;
            end else begin
                case (r_state)
                    c_CMD: if (w_rise) begin
                        r_shift <= w_shift_nxt[6:0];
                        if (w_last) begin
                            r_cnt       <= '0;
                            r_byte      <= w_shift_nxt;
                            r_cmd_stb   <= 1'b1;
                            r_dummy     <= w_dec_dummy;
                            r_out_mode  <= w_dec_mode;
                            r_addr_quad <= w_dec_quad;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    c_ADDR: if (w_rise) begin
                        r_addr <= r_addr_quad ? {r_addr[8*ADDR_BYTES-5:0], w_din}
                                              : {r_addr[8*ADDR_BYTES-2:0], w_din[0]};
                        if (w_last) begin
                            r_cnt      <= '0;
                            r_addr_stb <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + w_addr_step;
                        end
                    end
                    c_DUMMY: if (w_rise) r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
                    c_DATA_OUT: if (w_fall) begin
                        r_tx   <= w_tx_src[6:0];
                        r_dout <= w_dout_nxt;
                        if (r_cnt == 16'd0) r_tx_stb <= 1'b1;
                        r_cnt  <= w_last ? 16'd0 : r_cnt + 16'd1;
                    end
                    c_DATA_IN: if (w_rise) begin
                        r_shift <= w_shift_nxt[6:0];
                        if (w_last) begin
                            r_cnt      <= '0;
                            r_byte     <= w_shift_nxt;
                            r_byte_stb <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi_data_out    = r_dout;
    assign byte_rx         = r_byte;
    assign addr            = r_addr;
    assign spi_cmd_strobe  = r_cmd_stb;
    assign spi_addr_strobe = r_addr_stb;
    assign spi_byte_strobe = r_byte_stb;
    assign spi_tx_strobe   = r_tx_stb;

endmodule
`default_nettype wire

// File: doc/spi_multi_io.md
SPI_MULTI_IO -- requirements
Module: spi_multi_io

Interface
REQ-001 The block SHALL have parameter ADDR_BYTES, default 3: number of address bytes following an addressed read command.
REQ-002 The block SHALL have parameter DUMMY_FAST, default 8: dummy SPI clocks for commands 0x0B, 0x3B and 0x6B.
REQ-003 The block SHALL have parameter DUMMY_QIO, default 6: dummy SPI clocks for command 0xEB (2 mode clocks plus 4 dummy clocks).
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on spi_clk_in, spi_cs_in and spi_data_in.
REQ-005 The block SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-006 The block SHALL have port reset  input  1  synchronous active-low reset.
REQ-007 The block SHALL have port spi_clk_in  input  1  asynchronous SPI clock, mode 0.
REQ-008 The block SHALL have port spi_cs_in  input  1  asynchronous chip select, active-low.
REQ-009 The block SHALL have port spi_data_in  input  4  IO lanes in; lane 0 is MOSI in single mode.
REQ-010 The block SHALL have port spi_data_out  output  4  IO lanes out; lane 1 is MISO in single mode.
REQ-011 The block SHALL have port spi_data_oe  output  4  per-lane output enable.
REQ-012 The block SHALL have port byte  output  8  last received byte.
REQ-013 The block SHALL have port byte_tx  input  8  next byte to transmit.
REQ-014 The block SHALL have port addr  output  8*ADDR_BYTES  received address, MSB first.
REQ-015 The block SHALL have port spi_cmd_strobe  output  1  one-clk pulse: byte holds the command.
REQ-016 The block SHALL have port spi_addr_strobe  output  1  one-clk pulse: addr is complete.
REQ-017 The block SHALL have port spi_byte_strobe  output  1  one-clk pulse: byte holds a data byte received in DATA_IN.
REQ-018 The block SHALL have port spi_tx_strobe  output  1  one-clk pulse: byte_tx was loaded; the user presents the next byte.

Function
REQ-019 The block SHALL pass all SPI inputs through SYNC_STAGES flops; edges SHALL be detected on the synchronised spi_clk. SPI clock high and low times SHALL each be at least 3 clk periods.
REQ-020 The block SHALL sample input lanes on a detected spi_clk rise and SHALL update output lanes on a detected fall.
REQ-021 The FSM SHALL have states IDLE, CMD, ADDR, DUMMY, DATA_OUT and DATA_IN.
REQ-022 The FSM SHALL move IDLE->CMD when synchronised cs falls. CMD SHALL receive 8 bits on lane 0, MSB first.
REQ-023 After the 8th command bit, the block SHALL pulse spi_cmd_strobe with byte = command, 1 clk after the detected rise.
REQ-024 Command 0x03 SHALL select a single-lane address, no dummy clocks and single-lane output.
REQ-025 Command 0x0B SHALL select a single-lane address, DUMMY_FAST dummy clocks and single-lane output.
REQ-026 Command 0x3B SHALL select a single-lane address, DUMMY_FAST dummy clocks and 2-lane output (lanes 1:0, bit 7 on lane 1).
REQ-027 Command 0x6B SHALL select a single-lane address, DUMMY_FAST dummy clocks and 4-lane output.
REQ-028 Command 0xEB SHALL select a 4-lane address (lane 3 = MSB nibble), DUMMY_QIO dummy clocks and 4-lane output.
REQ-029 Any other command SHALL go to DATA_IN, which receives single-lane bytes, each followed by spi_byte_strobe; nothing is driven.
REQ-030 ADDR SHALL shift ADDR_BYTES*8 bits. spi_addr_strobe SHALL pulse once, 1 clk after the final rise, with addr valid until the next command.
REQ-031 DUMMY SHALL count the configured number of rises. A count of 0 SHALL skip DUMMY.
REQ-032 DATA_OUT SHALL load byte_tx into the shift register on the fall that starts each byte, and SHALL pulse spi_tx_strobe 1 clk later.
REQ-033 DATA_OUT SHALL shift 1, 2 or 4 bits per fall, MSB first. After the last bit of a byte it SHALL reload and continue without gaps until cs rises.
REQ-034 spi_data_oe SHALL equal 4'b0010, 4'b0011 or 4'b1111 in DATA_OUT (single, dual, quad), and 4'b0000 in every other state.
REQ-035 A cs rise in any state SHALL discard partial bits, issue no strobe, clear oe on the next clk, and return to IDLE.
REQ-036 A cs rise coincident with the final bit SHALL discard that byte, with no strobe.
REQ-037 Strobes SHALL be mutually exclusive; at most one pulse SHALL occur per byte.

Reset
REQ-038 While reset=0 at a clk edge, the block SHALL set state=IDLE, byte=0, addr=0, all strobes=0, spi_data_out=0 and spi_data_oe=0, and SHALL clear the synchronisers to cs=1, clk=0.
REQ-039 A reset asserted mid-transaction SHALL abort it. After release, the block SHALL wait for a fresh cs fall; a transaction already in progress at release SHALL be ignored.

Verification
REQ-040 Scenario: cs low, send 03 A5 5A 01 single-lane -> spi_cmd_strobe with byte=03; spi_addr_strobe with addr=A55A01; first tx byte on lane 1 with oe=0010.
REQ-041 Scenario: cs low, send EB, then quad address 10 20 30, 6 dummy clocks, byte_tx=C3 -> addr=102030; lanes output C then 3; oe=1111; spi_tx_strobe once per byte.
REQ-042 Scenario: command 3B, byte_tx incremented on each spi_tx_strobe from 00 -> lanes 1:0 output 00 00 00 00 00 00 00 01 (bit pairs); oe=0011.
REQ-043 Scenario: command 02 followed by 22 11 -> spi_cmd_strobe byte=02, then two spi_byte_strobe pulses with byte=22 and byte=11; oe=0 throughout.
REQ-044 Scenario: cs rises after 5 address bits -> no spi_addr_strobe, oe=0, state=IDLE; next transaction 03 00 00 00 decodes correctly.
REQ-045 Scenario: reset=0 during DATA_OUT -> all outputs reach reset values on the next clk; no strobes until a new cs fall after release.
